// File: rtl/iccm_port_arbiter_if.sv
// iccm_port_arbiter_if: loader/bus request-response bundle plus SRAM macro pins.
// slave = arbiter side; master = requesters and SRAM model side.
interface iccm_port_arbiter_if #(
  parameter int AW = 12,
  parameter int DW = 32
);
  logic          ld_req_i;
  logic          ld_we_i;
  logic          ld_lock_i;
  logic [AW-1:0] ld_addr_i;
  logic [DW-1:0] ld_wdata_i;
  logic [3:0]    ld_wmask_i;
  logic          ld_gnt_o;
  logic          ld_rvalid_o;
  logic [DW-1:0] ld_rdata_o;

  logic          bus_req_i;
  logic          bus_we_i;
  logic [AW-1:0] bus_addr_i;
  logic [DW-1:0] bus_wdata_i;
  logic [3:0]    bus_wmask_i;
  logic          bus_gnt_o;
  logic          bus_rvalid_o;
  logic [DW-1:0] bus_rdata_o;

  logic          sram_csb_o;
  logic          sram_web_o;
  logic [AW-1:0] sram_addr_o;
  logic [DW-1:0] sram_wdata_o;
  logic [3:0]    sram_wmask_o;
  logic [DW-1:0] sram_rdata_i;

  logic          owner_o;

  modport slave (
    input  ld_req_i, ld_we_i, ld_lock_i,
    input  ld_addr_i, ld_wdata_i, ld_wmask_i,
    output ld_gnt_o, ld_rvalid_o, ld_rdata_o,
    input  bus_req_i, bus_we_i,
    input  bus_addr_i, bus_wdata_i, bus_wmask_i,
    output bus_gnt_o, bus_rvalid_o, bus_rdata_o,
    output sram_csb_o, sram_web_o, sram_addr_o,
    output sram_wdata_o, sram_wmask_o,
    input  sram_rdata_i,
    output owner_o
  );

  modport master (
    output ld_req_i, ld_we_i, ld_lock_i,
    output ld_addr_i, ld_wdata_i, ld_wmask_i,
    input  ld_gnt_o, ld_rvalid_o, ld_rdata_o,
    output bus_req_i, bus_we_i,
    output bus_addr_i, bus_wdata_i, bus_wmask_i,
    input  bus_gnt_o, bus_rvalid_o, bus_rdata_o,
    input  sram_csb_o, sram_web_o, sram_addr_o,
    input  sram_wdata_o, sram_wmask_o,
    output sram_rdata_i,
    input  owner_o
  );
endinterface

// File: rtl/iccm_port_arbiter.sv
// iccm_port_arbiter: shares one single-port ICCM SRAM between loader and bus.
// Ports: clk_i, rst_ni (sync, active-low), io (iccm_port_arbiter_if.slave).
// Macro ICCM_ARB_RR_EN selects round-robin on contention; else loader first.
module iccm_port_arbiter #(
  parameter int         AW      = 12,
  parameter int         DW      = 32,
  parameter logic [3:0] MaxWait = 4'd15
) (
  input logic                clk_i,
  input logic                rst_ni,
  iccm_port_arbiter_if.slave io
);

  typedef enum logic {
    S_ARB,
    S_LD_LOCK
  } state_e;

  state_e     r_state;
  logic [3:0] r_wait;
  logic       r_rsp_vld;
  logic       r_rsp_bus;
  logic       r_rsp_rd;
  logic       r_owner;
`ifdef ICCM_ARB_RR_EN
  // 1: bus has priority on the next contention
  logic       r_rr;
`endif

  logic w_ld_gnt;
  logic w_bus_gnt;
  logic w_any;
  logic w_starve;
  logic w_both;

  assign w_starve = (r_wait == MaxWait);
  assign w_both   = io.ld_req_i & io.bus_req_i;
  assign w_any    = w_ld_gnt | w_bus_gnt;

  always_comb begin
    w_ld_gnt  = 1'b0;
    w_bus_gnt = 1'b0;
    if (rst_ni) begin
      unique case (r_state)
        S_LD_LOCK: w_ld_gnt = io.ld_req_i;
        default: begin
          if (w_both) begin
            if (w_starve) begin
              w_bus_gnt = 1'b1;
`ifdef ICCM_ARB_RR_EN
            end else if (r_rr) begin
              w_bus_gnt = 1'b1;
`endif
            end else begin
              w_ld_gnt = 1'b1;
            end
          end else begin
            w_ld_gnt  = io.ld_req_i;
            w_bus_gnt = io.bus_req_i;
          end
        end
      endcase
    end
  end

  assign io.ld_gnt_o  = w_ld_gnt;
  assign io.bus_gnt_o = w_bus_gnt;

  always_comb begin
    io.sram_csb_o   = 1'b1;
    io.sram_web_o   = 1'b1;
    io.sram_addr_o  = '0;
    io.sram_wdata_o = '0;
    io.sram_wmask_o = '0;
    unique case (1'b1)
      w_ld_gnt: begin
        io.sram_csb_o   = 1'b0;
        io.sram_web_o   = ~io.ld_we_i;
        io.sram_addr_o  = io.ld_addr_i;
        io.sram_wdata_o = io.ld_wdata_i;
        io.sram_wmask_o = io.ld_wmask_i;
      end
      w_bus_gnt: begin
        io.sram_csb_o   = 1'b0;
        io.sram_web_o   = ~io.bus_we_i;
        io.sram_addr_o  = io.bus_addr_i;
        io.sram_wdata_o = io.bus_wdata_i;
        io.sram_wmask_o = io.bus_wmask_i;
      end
      default: ;
    endcase
  end

  // Response follows the tag captured at grant; writes return zero data.
  assign io.ld_rvalid_o  = r_rsp_vld & ~r_rsp_bus;
  assign io.bus_rvalid_o = r_rsp_vld &  r_rsp_bus;
  assign io.ld_rdata_o   =
    (io.ld_rvalid_o & r_rsp_rd) ? io.sram_rdata_i : '0;
  assign io.bus_rdata_o  =
    (io.bus_rvalid_o & r_rsp_rd) ? io.sram_rdata_i : '0;
  assign io.owner_o      = r_owner;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state   <= S_ARB;
      r_wait    <= '0;
      r_rsp_vld <= 1'b0;
      r_rsp_bus <= 1'b0;
      r_rsp_rd  <= 1'b0;
      r_owner   <= 1'b0;
`ifdef ICCM_ARB_RR_EN
      r_rr      <= 1'b0;
`endif
    end else begin
      r_rsp_vld <= w_any;
      if (w_any) begin
        r_rsp_bus <= w_bus_gnt;
        r_rsp_rd  <= w_bus_gnt ? ~io.bus_we_i : ~io.ld_we_i;
        r_owner   <= w_bus_gnt;
`ifdef ICCM_ARB_RR_EN
        r_rr      <= w_ld_gnt;
`endif
      end

      if (!io.bus_req_i || w_bus_gnt) begin
        r_wait <= '0;
      end else if (r_wait != 4'hF) begin
        r_wait <= r_wait + 4'd1;
      end

      unique case (r_state)
        S_LD_LOCK: begin
          if (!io.ld_req_i || !io.ld_lock_i) begin
            r_state <= S_ARB;
          end
        end
        default: begin
          if (w_ld_gnt && io.ld_lock_i) begin
            r_state <= S_LD_LOCK;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iccm_port_arbiter.sv
// tb_iccm_port_arbiter: directed bench for iccm_port_arbiter.
// Behavioural SRAM model; summary line reports checks and errors.
module tb_iccm_port_arbiter;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] mem [0:1023];
  logic        eb;
  logic        pb;

  iccm_port_arbiter_if u_if ();

  iccm_port_arbiter u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .io     (u_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!u_if.sram_csb_o) begin
      if (!u_if.sram_web_o) begin
        for (int b = 0; b < 4; b++) begin
          if (u_if.sram_wmask_o[b]) begin
            mem[u_if.sram_addr_o[9:0]][b*8 +: 8] =
              u_if.sram_wdata_o[b*8 +: 8];
          end
        end
      end else begin
        u_if.sram_rdata_i <= mem[u_if.sram_addr_o[9:0]];
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic idle();
    u_if.ld_req_i    = 1'b0;
    u_if.ld_we_i     = 1'b0;
    u_if.ld_lock_i   = 1'b0;
    u_if.ld_addr_i   = '0;
    u_if.ld_wdata_i  = '0;
    u_if.ld_wmask_i  = '0;
    u_if.bus_req_i   = 1'b0;
    u_if.bus_we_i    = 1'b0;
    u_if.bus_addr_i  = '0;
    u_if.bus_wdata_i = '0;
    u_if.bus_wmask_i = '0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  function automatic logic [31:0] gnts();
    return {30'd0, u_if.ld_gnt_o, u_if.bus_gnt_o};
  endfunction

  function automatic logic [31:0] rvs();
    return {30'd0, u_if.ld_rvalid_o, u_if.bus_rvalid_o};
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    mem[16] = 32'hDEADBEEF;
    mem[32] = 32'hCAFEF00D;
    idle();

    // reset: requests present but nothing granted
    u_if.ld_req_i  = 1'b1;
    u_if.bus_req_i = 1'b1;
    smp();
    chk("rst_gnt", gnts(), 32'd0);
    chk("rst_csb", 32'(u_if.sram_csb_o), 32'd1);
    chk("rst_web", 32'(u_if.sram_web_o), 32'd1);
    nxt();
    idle();
    rst_n = 1'b1;
    smp();
    chk("rst_rv", rvs(), 32'd0);
    chk("rst_own", 32'(u_if.owner_o), 32'd0);
    chk("rst_ldrd", u_if.ld_rdata_o, 32'd0);

    // single bus read
    nxt();
    u_if.bus_req_i  = 1'b1;
    u_if.bus_addr_i = 12'h010;
    smp();
    chk("br_gnt", gnts(), 32'd1);
    chk("br_csb", 32'(u_if.sram_csb_o), 32'd0);
    chk("br_web", 32'(u_if.sram_web_o), 32'd1);
    chk("br_addr", 32'(u_if.sram_addr_o), 32'h010);
    nxt();
    idle();
    smp();
    chk("br_rv", rvs(), 32'd1);
    chk("br_rd", u_if.bus_rdata_o, 32'hDEADBEEF);
    chk("br_ldrd", u_if.ld_rdata_o, 32'd0);
    chk("br_own", 32'(u_if.owner_o), 32'd1);
    chk("br_idle", 32'(u_if.sram_csb_o), 32'd1);

    // contention, both writing every cycle
    pb = 1'b0;
    for (int k = 0; k < 32; k++) begin
      nxt();
      u_if.ld_req_i    = 1'b1;
      u_if.ld_we_i     = 1'b1;
      u_if.ld_addr_i   = 12'h100;
      u_if.ld_wdata_i  = 32'h11111111;
      u_if.ld_wmask_i  = 4'hF;
      u_if.bus_req_i   = 1'b1;
      u_if.bus_we_i    = 1'b1;
      u_if.bus_addr_i  = 12'h200;
      u_if.bus_wdata_i = 32'h22222222;
      u_if.bus_wmask_i = 4'hF;
      smp();
`ifdef ICCM_ARB_RR_EN
      eb = (k % 2) == 1;
`else
      eb = (k % 16) == 15;
`endif
      chk($sformatf("ct_gnt%0d", k), gnts(), {30'd0, ~eb, eb});
      if (k > 0) begin
        chk($sformatf("ct_rv%0d", k), rvs(), {30'd0, ~pb, pb});
        chk($sformatf("ct_rd%0d", k),
            u_if.ld_rdata_o | u_if.bus_rdata_o, 32'd0);
      end
      pb = eb;
    end
    nxt();
    idle();
    smp();
    chk("ct_rvlast", rvs(), {30'd0, ~pb, pb});

    // locked burst while the bus keeps asking
    for (int i = 0; i < 8; i++) begin
      nxt();
      u_if.ld_req_i   = 1'b1;
      u_if.ld_we_i    = 1'b1;
      u_if.ld_lock_i  = 1'b1;
      u_if.ld_addr_i  = 12'(i);
      u_if.ld_wdata_i = 32'hA5000000 | 32'(i);
      u_if.ld_wmask_i = 4'hF;
      u_if.bus_req_i  = 1'b1;
      u_if.bus_we_i   = 1'b0;
      u_if.bus_addr_i = 12'h010;
      smp();
      chk($sformatf("lk_gnt%0d", i), gnts(), 32'd2);
    end
    nxt();
    u_if.ld_req_i  = 1'b0;
    u_if.ld_we_i   = 1'b0;
    u_if.ld_lock_i = 1'b0;
    smp();
    chk("lk_rel", gnts(), 32'd0);
    nxt();
    smp();
    chk("lk_bus", gnts(), 32'd1);
    nxt();
    idle();
    smp();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("lk_mem%0d", i), mem[i], 32'hA5000000 | 32'(i));
    end

    // masked loader write then bus read of the same word
    nxt();
    u_if.ld_req_i   = 1'b1;
    u_if.ld_we_i    = 1'b1;
    u_if.ld_addr_i  = 12'h020;
    u_if.ld_wdata_i = 32'h11223344;
    u_if.ld_wmask_i = 4'b0011;
    smp();
    chk("wr_gnt", gnts(), 32'd2);
    nxt();
    idle();
    u_if.bus_req_i  = 1'b1;
    u_if.bus_addr_i = 12'h020;
    smp();
    chk("wr_bgnt", gnts(), 32'd1);
    chk("wr_ldrv", rvs(), 32'd2);
    chk("wr_ldrd", u_if.ld_rdata_o, 32'd0);
    nxt();
    idle();
    smp();
    chk("wr_brv", rvs(), 32'd1);
    chk("wr_brd", u_if.bus_rdata_o, 32'hCAFE3344);

    // reset while locked with a read outstanding
    nxt();
    u_if.ld_req_i  = 1'b1;
    u_if.ld_lock_i = 1'b1;
    u_if.ld_addr_i = 12'h010;
    smp();
    chk("mr_gnt", gnts(), 32'd2);
    nxt();
    rst_n          = 1'b0;
    u_if.bus_req_i = 1'b1;
    smp();
    chk("mr_rgnt", gnts(), 32'd0);
    chk("mr_csb", 32'(u_if.sram_csb_o), 32'd1);
    chk("mr_web", 32'(u_if.sram_web_o), 32'd1);
    nxt();
    smp();
    chk("mr_rv", rvs(), 32'd0);
    chk("mr_rd", u_if.ld_rdata_o | u_if.bus_rdata_o, 32'd0);
    chk("mr_csb2", 32'(u_if.sram_csb_o), 32'd1);
    chk("mr_own", 32'(u_if.owner_o), 32'd0);
    nxt();
    rst_n           = 1'b1;
    u_if.ld_req_i   = 1'b0;
    u_if.ld_lock_i  = 1'b0;
    u_if.bus_addr_i = 12'h010;
    smp();
    chk("mr_bgnt", gnts(), 32'd1);
    nxt();
    idle();
    smp();
    chk("mr_brv", rvs(), 32'd1);
    chk("mr_brd", u_if.bus_rdata_o, 32'hDEADBEEF);
    chk("mr_bown", 32'(u_if.owner_o), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/iccm_port_arbiter.md
# iccm_port_arbiter

Two-port arbiter that shares the single-port 32x1024 instruction SRAM between the UART program loader's write port and the TL-UL instruction-memory bus adapter. Each cycle it grants at most one requester and drives that requester's access onto the SRAM macro pins. It returns a one-cycle-later response to the granted requester. It also supports a locked burst for the loader and a starvation guard that protects the bus side.

## Interface
- AW, 12, SRAM word-address width
- DW, 32, data width
- MaxWait, 15, bus-side waiting cycles before a forced bus grant (4-bit counter)

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  reset; synchronous, active-low
- ld_req_i  in  1  loader access request
- ld_we_i  in  1  loader write (1) / read (0)
- ld_lock_i  in  1  hold ownership after the current grant
- ld_addr_i  in  AW  loader word address
- ld_wdata_i  in  DW  loader write data
- ld_wmask_i  in  4  loader byte mask
- ld_gnt_o  out  1  loader access accepted this cycle
- ld_rvalid_o  out  1  loader response
- ld_rdata_o  out  DW  loader read data
- bus_req_i, bus_we_i, bus_addr_i, bus_wdata_i, bus_wmask_i  in  1/1/AW/DW/4  bus-adapter request, same meaning as the loader signals
- bus_gnt_o  out  1  bus access accepted
- bus_rvalid_o  out  1  bus response
- bus_rdata_o  out  DW  bus read data
- sram_csb_o  out  1  SRAM chip select, active-low
- sram_web_o  out  1  SRAM write enable, active-low
- sram_addr_o  out  AW  SRAM address
- sram_wdata_o  out  DW  SRAM write data
- sram_wmask_o  out  4  SRAM byte mask
- sram_rdata_i  in  DW  SRAM read data, valid one cycle after a read
- owner_o  out  1  registered owner of the last grant (0 = loader, 1 = bus)

## Operation
- FSM states:
  - ARB: per-cycle arbitration.
  - LD_LOCK: loader owns the SRAM exclusively.
- In ARB, a single requester is granted immediately.
- In ARB, when both request, the winner depends on the policy (see Configuration).
- Starvation guard overrides the policy: wait_cnt increments each cycle bus_req_i=1 and bus_gnt_o=0.
  - It saturates at 15 and clears on bus grant or when bus_req_i=0.
  - When wait_cnt == MaxWait, the bus wins in ARB.
- ARB to LD_LOCK: on a loader grant with ld_lock_i=1.
- In LD_LOCK:
  - Only the loader is granted; bus_gnt_o=0.
  - wait_cnt keeps counting.
- LD_LOCK to ARB: at the end of any cycle with ld_req_i=0 or ld_lock_i=0.
- Granted access: the SRAM pins carry the winner's addr/wdata/wmask.
  - sram_csb_o=0.
  - sram_web_o = ~we.
- No grant: sram_csb_o=1, sram_web_o=1, addr/wdata/wmask=0.
- Every granted access (read or write) produces exactly one rvalid pulse to its requester.
  - rdata = sram_rdata_i for reads.
  - rdata = 0 for writes.
- The response tag (owner, is_read) is registered at grant.
- The non-owner's rdata is 0.

## Timing
- ld_gnt_o, bus_gnt_o and the SRAM pins are combinational from the requests and the registered state; the SRAM samples on the next clk_i rising edge.
- Response latency is exactly 1 cycle after grant. Back-to-back grants give back-to-back rvalid with no bubble.
- Requests are level-held: a requester keeps req and its payload stable until it sees gnt.
- Ownership may switch every cycle; no turnaround cycle is inserted.
- Reset is applied on a rising edge with rst_ni=0:
  - state=ARB, wait_cnt=0, rr pointer=loader, owner_o=0.
  - Pending responses are discarded; both rvalid=0 and both rdata=0.
  - While rst_ni=0, both gnt=0, sram_csb_o=1, sram_web_o=1.
- Reset in LD_LOCK returns the FSM to ARB.

## Configuration
- ICCM_ARB_RR_EN defined: round-robin policy.
  - On contention in ARB, the requester not granted last wins.
  - The rr pointer updates on every grant.
- ICCM_ARB_RR_EN undefined: fixed priority, loader over bus on contention.
- The starvation guard and LD_LOCK behave identically in both builds.

## Test plan
- Single bus read: SRAM addr 0x010 preloaded with 0xDEADBEEF; bus_req=1, we=0, addr=0x010.
  - Same cycle: bus_gnt=1, sram_csb_o=0, sram_web_o=1.
  - Next cycle: bus_rvalid=1, bus_rdata=0xDEADBEEF; ld_rvalid=0.
- Contention, both request every cycle (writes):
  - Without the macro: loader granted 15 cycles, then the bus once (wait_cnt hits 15), repeating.
  - With the macro: grants alternate loader/bus every cycle.
- Locked burst: loader writes 0x000-0x007 with ld_lock=1 while the bus requests continuously.
  - bus_gnt=0 for all 8 cycles.
  - First bus grant comes the cycle after ld_lock drops.
  - SRAM holds the written data.
- Loader write followed by a bus read of the same address back-to-back: bus_rdata equals the loader's wdata, respecting wmask=4'b0011.
- Reset mid-burst: assert rst_ni=0 in LD_LOCK with a read outstanding.
  - Next cycle: no rvalid, sram_csb_o=1, both gnt=0.
  - After release, the bus alone is granted immediately.
